// File: rtl/seq_alu.sv
// Handshaked, parametrised ALU with registered result/flags and an iterative
// shift-add multiplier; one operation in flight at a time.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               hi_q, hi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Single-cycle datapath, evaluated straight from the presented operands.
  logic             is_sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] simple_res;
  logic             simple_ovf;
  logic             simple_cout;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    simple_res  = '0;
    simple_ovf  = 1'b0;
    simple_cout = 1'b0;
    is_sub      = (ALUop == OP_SUB);
    b_x         = is_sub ? ~B : B;
    sum         = {1'b0, A} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
    sum_ovf     = (A[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    case (ALUop)
      OP_AND:  simple_res = A & B;
      OP_OR:   simple_res = A | B;
      OP_XOR:  simple_res = A ^ B;
      OP_NOR:  simple_res = ~(A | B);
      OP_ADD:  begin
        simple_res  = sum[WIDTH-1:0];
        simple_ovf  = sum_ovf;
        simple_cout = sum[WIDTH];
      end
      OP_SUB:  begin
        simple_res  = sum[WIDTH-1:0];
        simple_ovf  = sum_ovf;
        simple_cout = ~sum[WIDTH];
      end
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, A < B};
      default: simple_res = '0;
    endcase
  end

  // One shift-add step: conditional add into the upper half, then shift right with carry.
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    upper    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {upper, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
    zero_d      = zero_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (ALUop == OP_MUL || ALUop == OP_MULHU) begin
            state_d  = BUSY;
            mcand_d  = A;
            mplier_d = B;
            hi_d     = (ALUop == OP_MULHU);
            cnt_d    = '0;
            acc_d    = '0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = simple_res;
            ovf_d       = simple_ovf;
            cout_d      = simple_cout;
            zero_d      = (simple_res == '0);
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
          ovf_d       = 1'b0;
          cout_d      = 1'b0;
          zero_d      = (result_d == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      hi_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = cout_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit and an 8-bit instance share stimulus;
// expected results come from an arithmetic model through a scoreboard queue.
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        cout;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid32, in_valid8;
  logic        in_ready32, in_ready8;
  logic [31:0] A, B;
  logic [3:0]  ALUop;
  logic        out_ready;
  logic        out_valid32, out_valid8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic        ovf32, cout32, zero32, ovf8, cout8, zero8;

  int   total = 0;
  int   bad   = 0;
  logic sel8  = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(A), .B(B), .ALUop(ALUop), .out_valid(out_valid32), .out_ready(out_ready),
    .Result(res32), .Overflow(ovf32), .CarryOut(cout32), .Zero(zero32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A[7:0]), .B(B[7:0]), .ALUop(ALUop), .out_valid(out_valid8), .out_ready(out_ready),
    .Result(res8), .Overflow(ovf8), .CarryOut(cout8), .Zero(zero8)
  );

  logic        cur_ready, cur_valid, cur_ovf, cur_cout, cur_zero;
  logic [31:0] cur_res;
  assign cur_ready = sel8 ? in_ready8 : in_ready32;
  assign cur_valid = sel8 ? out_valid8 : out_valid32;
  assign cur_res   = sel8 ? {24'd0, res8} : res32;
  assign cur_ovf   = sel8 ? ovf8 : ovf32;
  assign cur_cout  = sel8 ? cout8 : cout32;
  assign cur_zero  = sel8 ? zero8 : zero32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a_in,
                                 input logic [63:0] b_in, input int w);
    logic [63:0] mask, a, b, r;
    longint      as, bs, s, maxv, minv;
    exp_t        e;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    as   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    bs   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    r = '0; e.ovf = 1'b0; e.cout = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ~(a | b) & mask;
      4'b0010: begin
        r = (a + b) & mask; e.cout = ((a + b) >> w) != 0;
        s = as + bs; e.ovf = (s > maxv) || (s < minv);
      end
      4'b0110: begin
        r = (a - b) & mask; e.cout = (a < b);
        s = as - bs; e.ovf = (s > maxv) || (s < minv);
      end
      4'b0111: r = (as < bs) ? 64'd1 : 64'd0;
      4'b0011: r = (a < b) ? 64'd1 : 64'd0;
      4'b1000: r = (a * b) & mask;
      4'b1001: r = ((a * b) >> w) & mask;
      default: r = '0;
    endcase
    e.res  = r[31:0];
    e.zero = (r == 0);
    return e;
  endfunction

  task automatic set_valid(input logic v);
    if (sel8) in_valid8 = v;
    else      in_valid32 = v;
  endtask

  // Issue one op, wait for its result, optionally hold backpressure, then retire it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int   w, exp_lat, lat;
    logic rdy_seen;
    exp_t e;
    w       = sel8 ? 8 : 32;
    exp_lat = (op == 4'b1000 || op == 4'b1001) ? w + 1 : 1;
    exp_q.push_back(model(op, {32'd0, a}, {32'd0, b}, w));
    @(negedge clk);
    A = a; B = b; ALUop = op; set_valid(1'b1);
    check({tag, "_accept_ready"}, cur_ready, 1);
    @(posedge clk);
    @(negedge clk);
    set_valid(1'b0);
    A = $urandom; B = $urandom; ALUop = 4'($urandom);
    lat = 1; rdy_seen = 1'b0;
    while (!cur_valid && lat < 200) begin
      rdy_seen |= cur_ready;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_ready"}, rdy_seen | cur_ready, 0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_res"}, cur_res, e.res);
    check({tag, "_flags"}, {cur_ovf, cur_cout, cur_zero}, {e.ovf, e.cout, e.zero});
    if (hold > 0) begin
      set_valid(1'b1);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        A = $urandom; B = $urandom;
        if (i == hold - 2) set_valid(1'b0);
        check({tag, "_hold_held"}, {cur_valid, cur_ready, cur_res, cur_ovf, cur_cout, cur_zero},
              {1'b1, 1'b0, e.res, e.ovf, e.cout, e.zero});
      end
      set_valid(1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire"}, {cur_valid, cur_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid32 = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUop = '0;
    #12;
    check("reset32", {in_ready32, out_valid32, res32, ovf32, cout32, zero32}, {1'b1, 1'b0, 32'd0, 3'b000});
    check("reset8", {in_ready8, out_valid8, res8, ovf8, cout8, zero8}, {1'b1, 1'b0, 8'd0, 3'b000});
    rst_n = 1'b1;

    run_op("add_ovf",   4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("sub_borrow",4'b0110, 32'h0000_0000, 32'h0000_0001, 0);
    run_op("sub_ovf",   4'b0110, 32'h8000_0000, 32'h0000_0001, 5);
    run_op("slt",       4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("sltu",      4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op("xor",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("nor",       4'b0101, 32'h0000_0000, 32'h0000_0000, 5);
    run_op("illegal",   4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("mul_ff",    4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhu_ff",  4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mul_dec",   4'b1000, 32'd12345,     32'd6789,      5);

    // Abort a multiply with a half-cycle reset pulse; the pending result must vanish.
    @(negedge clk);
    A = 32'd1000; B = 32'd1000; ALUop = 4'b1000; in_valid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outs", {in_ready32, out_valid32, res32, ovf32, cout32, zero32},
          {1'b1, 1'b0, 32'd0, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= out_valid32;
    end
    check("midreset_no_stale", seen, 0);
    run_op("post_reset_add", 4'b0010, 32'h0000_0005, 32'h0000_0007, 0);

    sel8 = 1'b1;
    run_op("w8_mul",   4'b1000, 32'h0000_00FF, 32'h0000_00FF, 0);
    run_op("w8_mulhu", 4'b1001, 32'h0000_00FF, 32'h0000_00FF, 3);
    run_op("w8_add_ovf",   4'b0010, 32'h0000_007F, 32'h0000_0001, 0);
    run_op("w8_add_carry", 4'b0010, 32'h0000_00FF, 32'h0000_0001, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's 3-bit-opcode combinational ALU.
- Width is generic. Opcode widens to 4 bits and keeps the existing AND/OR/ADD/SUB/SLT encodings, so old decoders still work. Adds XOR, NOR, SLTU, and an iterative shift-add multiplier (low and high-unsigned halves).
- Sits between the decode/issue stage and writeback of the multi-cycle CPU. Result and flags are registered and held under backpressure.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept an op.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALUop  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- Result  out  WIDTH  registered result.
- Overflow  out  1  signed overflow (ADD/SUB only).
- CarryOut  out  1  ADD carry / SUB borrow.
- Zero  out  1  Result == 0.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
  - 0100 XOR, 0101 NOR, 0011 SLTU.
  - 1000 MUL (low WIDTH bits of A*B), 1001 MULHU (high WIDTH bits, unsigned).
  - All other codes are illegal: Result=0, Overflow=0, CarryOut=0, Zero=1, normal latency 1.
- Arithmetic rules:
  - ADD: CarryOut = carry out of bit WIDTH-1; Overflow = operands same sign and sum sign differs.
  - SUB: computed as A+~B+1; CarryOut = borrow = ~carry (1 iff A<B unsigned); Overflow = operand signs differ and result sign differs from A.
  - SLT (signed) and SLTU: Result = {0…,lt}.
  - Overflow and CarryOut are 0 for every op other than ADD/SUB. Zero is valid for all ops.
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, Result=0, Overflow=0, CarryOut=0, Zero=0, counter=0, partial product=0.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch A, B, ALUop.
    - MUL/MULHU -> BUSY, counter=0, 2*WIDTH-bit accumulator=0.
    - Any other op -> DONE, with Result/flags registered on the same edge.
  - BUSY: in_ready=0. Each cycle: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator; shift the accumulator right one bit with the carry; shift the multiplier right; counter++. After WIDTH iterations -> DONE, load Result from the low or high half.
  - DONE: out_valid=1, in_ready=0. On out_ready -> IDLE, out_valid=0.
- Latency, measured from the accepting edge to the first cycle out_valid=1: 1 cycle for simple ops, WIDTH+1 for MUL/MULHU. Throughput: one op in flight; no new accept while BUSY or DONE.
- Stability: while out_valid=1 and out_ready=0, Result and flags are held constant. Changes on A/B/ALUop after acceptance have no effect.
- Simultaneous events: out_ready with out_valid=0 is ignored. in_valid outside IDLE is ignored; the producer must hold it until in_ready.
- Reset mid-operation (BUSY or DONE): abort immediately, return to reset values, and drop the pending result.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> Result 0x80000000, Overflow=1, CarryOut=0, Zero=0. Then ADD 0xFFFFFFFF+1 -> Result 0, CarryOut=1, Zero=1. Both with out_valid exactly 1 cycle after accept.
- SUB 0-1 -> 0xFFFFFFFF, CarryOut=1, Overflow=0. SUB 0x80000000-1 -> 0x7FFFFFFF, Overflow=1.
- SLT A=0xFFFFFFFF, B=1 -> 1. SLTU on the same operands -> 0. XOR 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0. NOR 0,0 -> 0xFFFFFFFF. Illegal op 1111 -> Result 0, Zero=1.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. MULHU on the same operands -> 0xFFFFFFFE. MUL 12345*6789 -> 83810205. out_valid first high 33 cycles after accept, and in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> Result/flags stable and in_ready=0. Pulse in_valid during this window -> ignored. out_ready=1 -> IDLE next cycle, next op accepted.
- Drop rst_n for half a cycle 10 cycles into a MUL -> all outputs take reset values immediately and no stale result appears. Rerun the MUL/ADD vectors with WIDTH=8: 0xFF*0xFF -> low 0x01, high 0xFE, latency 9.
